// File: rtl/cve2_mac_ex_sequencer.sv
// EX-side MAC sequencer: accepts a MAC command, runs MULL on the shared multiplier, one ALU ADD, then returns the result.
// Optional signed saturation of the final add is enabled by defining CVE2_MAC_SAT_EN.
module cve2_mac_ex_sequencer #(
  parameter int unsigned DataWidth  = 32,
  parameter int unsigned MulTimeout = 40
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [DataWidth-1:0] cmd_op_a_i,
  input  logic [DataWidth-1:0] cmd_op_b_i,
  input  logic [DataWidth-1:0] cmd_acc_i,
  input  logic                 kill_i,
  output logic                 mul_req_o,
  output logic [DataWidth-1:0] mul_op_a_o,
  output logic [DataWidth-1:0] mul_op_b_o,
  input  logic                 mul_valid_i,
  input  logic [DataWidth-1:0] mul_result_i,
  output logic                 alu_add_en_o,
  output logic [DataWidth-1:0] alu_op_a_o,
  output logic [DataWidth-1:0] alu_op_b_o,
  input  logic [DataWidth-1:0] alu_result_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [DataWidth-1:0] res_data_o,
  output logic                 res_sat_o,
  output logic                 busy_o,
  output logic                 err_timeout_o
);

  localparam int unsigned CntW = $clog2(MulTimeout) + 1;
  localparam logic [CntW-1:0] CntMax = CntW'(MulTimeout - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic [DataWidth-1:0] op_a_q, op_b_q, acc_q, prod_q, res_q;
  logic                 accept, prod_en, res_en;
  logic [DataWidth-1:0] sum_final;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    prod_en = 1'b0;
    res_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i && !kill_i) begin
          state_d = MUL;
          cnt_d   = '0;
          accept  = 1'b1;
        end
      end
      MUL: begin
        // kill beats a returning product; a returning product beats the timeout
        if (kill_i) begin
          state_d = IDLE;
        end else if (mul_valid_i) begin
          state_d = ADD;
          prod_en = 1'b1;
        end else if (cnt_q == CntMax) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      ADD: begin
        if (kill_i) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
          res_en  = 1'b1;
        end
      end
      RESP: begin
        if (kill_i || res_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CVE2_MAC_SAT_EN
  logic sat_q;
  logic ovf;

  // Overflow only possible when both addends share a sign and the sum flips it
  assign ovf = (prod_q[DataWidth-1] == acc_q[DataWidth-1]) &&
               (alu_result_i[DataWidth-1] != acc_q[DataWidth-1]);
  assign sum_final = !ovf ? alu_result_i :
                     acc_q[DataWidth-1] ? {1'b1, {(DataWidth-1){1'b0}}} :
                                          {1'b0, {(DataWidth-1){1'b1}}};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sat_q <= 1'b0;
    end else if (res_en) begin
      sat_q <= ovf;
    end
  end

  assign res_sat_o = res_valid_o & sat_q;
`else
  assign sum_final = alu_result_i;
  assign res_sat_o = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (accept) begin
        op_a_q <= cmd_op_a_i;
        op_b_q <= cmd_op_b_i;
        acc_q  <= cmd_acc_i;
      end
      if (prod_en) begin
        prod_q <= mul_result_i;
      end
      if (res_en) begin
        res_q <= sum_final;
      end
    end
  end

  assign cmd_ready_o   = (state_q == IDLE);
  assign busy_o        = (state_q != IDLE);
  assign mul_req_o     = (state_q == MUL);
  assign alu_add_en_o  = (state_q == ADD);
  assign res_valid_o   = (state_q == RESP);
  assign err_timeout_o = err_q;

  assign mul_op_a_o = mul_req_o    ? op_a_q : '0;
  assign mul_op_b_o = mul_req_o    ? op_b_q : '0;
  assign alu_op_a_o = alu_add_en_o ? prod_q : '0;
  assign alu_op_b_o = alu_add_en_o ? acc_q  : '0;
  assign res_data_o = res_valid_o  ? res_q  : '0;

endmodule

// File: tb/tb_cve2_mac_ex_sequencer.sv
// Randomized bench for cve2_mac_ex_sequencer with a stub multiplier/ALU and an arithmetic reference model.
// Saturation expectations follow CVE2_MAC_SAT_EN when it is defined.
module tb_cve2_mac_ex_sequencer;

  localparam int MT = 40;

  logic        clk_i, rst_ni;
  logic        cmd_valid_i, cmd_ready_o, kill_i;
  logic [31:0] cmd_op_a_i, cmd_op_b_i, cmd_acc_i;
  logic        mul_req_o, mul_valid_i;
  logic [31:0] mul_op_a_o, mul_op_b_o, mul_result_i;
  logic        alu_add_en_o;
  logic [31:0] alu_op_a_o, alu_op_b_o, alu_result_i;
  logic        res_valid_o, res_ready_i, res_sat_o, busy_o, err_timeout_o;
  logic [31:0] res_data_o;

  int checks   = 0;
  int failures = 0;

  cve2_mac_ex_sequencer #(.DataWidth(32), .MulTimeout(MT)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_a_i(cmd_op_a_i), .cmd_op_b_i(cmd_op_b_i), .cmd_acc_i(cmd_acc_i),
    .kill_i(kill_i),
    .mul_req_o(mul_req_o), .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .alu_add_en_o(alu_add_en_o), .alu_op_a_o(alu_op_a_o), .alu_op_b_o(alu_op_b_o),
    .alu_result_i(alu_result_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o),
    .res_sat_o(res_sat_o), .busy_o(busy_o), .err_timeout_o(err_timeout_o)
  );

  // Stub execution units: multiplier low half and a combinational adder
  assign mul_result_i = mul_op_a_o * mul_op_b_o;
  assign alu_result_i = alu_op_a_o + alu_op_b_o;

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: acc + low(a*b) as signed integers, optionally clamped to the 32-bit signed range
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                                output logic [31:0] r, output logic s);
    logic [31:0] p;
    longint      sum;
    p   = a * b;
    sum = longint'($signed(p)) + longint'($signed(acc));
    r   = sum[31:0];
    s   = 1'b0;
`ifdef CVE2_MAC_SAT_EN
    if (sum > 64'sd2147483647) begin
      r = 32'h7FFF_FFFF;
      s = 1'b1;
    end else if (sum < -64'sd2147483648) begin
      r = 32'h8000_0000;
      s = 1'b1;
    end
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, cmd_ready_o, 1);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_mulreq"}, mul_req_o, 0);
    check({tag, "_adden"}, alu_add_en_o, 0);
    check({tag, "_resvalid"}, res_valid_o, 0);
    check({tag, "_resdata"}, res_data_o, 0);
    check({tag, "_err"}, err_timeout_o, 0);
  endtask

  // mode: 0 normal, 1 kill in MUL, 2 kill in ADD, 3 kill in RESP, 4 reset in RESP
  task automatic do_mac(input logic [31:0] a, input logic [31:0] b, input logic [31:0] acc,
                        input int mdel, input int rdel, input int mode);
    logic [31:0] er;
    logic        es;
    model(a, b, acc, er, es);
    $display("MAC a=%h b=%h acc=%h mdel=%0d rdel=%0d mode=%0d exp=%h sat=%0d",
             a, b, acc, mdel, rdel, mode, er, es);
    check("accept_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_op_a_i = a; cmd_op_b_i = b; cmd_acc_i = acc;
    step();
    cmd_valid_i = 1'b0; cmd_op_a_i = $urandom; cmd_op_b_i = $urandom; cmd_acc_i = $urandom;
    for (int i = 0; i <= mdel; i++) begin
      check("mul_req", mul_req_o, 1);
      check("mul_op_a", mul_op_a_o, a);
      check("mul_op_b", mul_op_b_o, b);
      check("mul_ready", cmd_ready_o, 0);
      check("mul_resvalid", res_valid_o, 0);
      if (mode == 1 && i == mdel) begin
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check_idle("kill_mul");
        mul_valid_i = 1'b1;
        step();
        mul_valid_i = 1'b0;
        check_idle("late_mulvalid");
        return;
      end
      if (i == mdel) mul_valid_i = 1'b1;
      step();
    end
    mul_valid_i = 1'b0;
    check("add_en", alu_add_en_o, 1);
    check("add_mulreq", mul_req_o, 0);
    check("alu_op_a", alu_op_a_o, a * b);
    check("alu_op_b", alu_op_b_o, acc);
    if (mode == 2) begin
      kill_i = 1'b1;
      step();
      kill_i = 1'b0;
      check_idle("kill_add");
      return;
    end
    step();
    for (int j = 0; j <= rdel; j++) begin
      check("res_valid", res_valid_o, 1);
      check("res_data", res_data_o, er);
      check("res_sat", res_sat_o, es);
      check("resp_ready", cmd_ready_o, 0);
      if (mode == 3 && j == rdel) begin
        kill_i = 1'b1;
        step();
        kill_i = 1'b0;
        check_idle("kill_resp");
        return;
      end
      if (mode == 4 && j == rdel) begin
        #2 rst_ni = 1'b0;
        #1;
        check_idle("rst_resp");
        check("rst_sat", res_sat_o, 0);
        step();
        rst_ni = 1'b1;
        step();
        check_idle("rst_release");
        return;
      end
      res_ready_i = (j == rdel);
      step();
    end
    res_ready_i = 1'b0;
    check_idle("post_resp");
  endtask

  task automatic do_timeout(input logic [31:0] a, input logic [31:0] b);
    $display("TIMEOUT a=%h b=%h cycles=%0d", a, b, MT);
    cmd_valid_i = 1'b1; cmd_op_a_i = a; cmd_op_b_i = b; cmd_acc_i = 32'h1;
    step();
    cmd_valid_i = 1'b0;
    for (int i = 0; i < MT; i++) begin
      check("to_mulreq", mul_req_o, 1);
      check("to_err_early", err_timeout_o, 0);
      step();
    end
    check("to_err_pulse", err_timeout_o, 1);
    check("to_mulreq_drop", mul_req_o, 0);
    check("to_resvalid", res_valid_o, 0);
    check("to_ready", cmd_ready_o, 1);
    step();
    check_idle("to_after");
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] sp [6];
    sp = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h4000_0000};
    if ($urandom_range(0, 2) == 0) return sp[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    cmd_valid_i = 1'b0; kill_i = 1'b0; mul_valid_i = 1'b0; res_ready_i = 1'b0;
    cmd_op_a_i = '0; cmd_op_b_i = '0; cmd_acc_i = '0;
    #12;
    check_idle("reset");
    check("reset_sat", res_sat_o, 0);
    step();
    rst_ni = 1'b1;
    step();

    // basic: product returns one cycle after the first request cycle -> result at cycle 4
    do_mac(32'd3, 32'd5, 32'd7, 1, 0, 0);
    // backpressure
    do_mac(32'd11, 32'd13, 32'd100, 2, 5, 0);
    // wrap / saturation boundary vectors
    do_mac(32'h4000_0000, 32'd2, 32'h7FFF_FFFF, 0, 0, 0);
    do_mac(32'h4000_0000, 32'd1, 32'h4000_0000, 0, 0, 0);
    do_mac(32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 0, 1, 0);
    // product arrives on the last permitted cycle
    do_mac(32'd6, 32'd7, 32'd1, MT - 1, 0, 0);
    do_timeout(32'd9, 32'd9);
    // kill in IDLE with a command present
    $display("KILL_IDLE");
    cmd_valid_i = 1'b1; kill_i = 1'b1; cmd_op_a_i = 32'd1; cmd_op_b_i = 32'd1;
    step();
    cmd_valid_i = 1'b0; kill_i = 1'b0;
    check_idle("kill_idle");
    do_mac(32'd4, 32'd4, 32'd4, 2, 0, 1);
    do_mac(32'd4, 32'd5, 32'd6, 0, 0, 2);
    do_mac(32'd7, 32'd8, 32'd9, 1, 2, 3);
    do_mac(32'd10, 32'd10, 32'd10, 1, 1, 4);
    do_mac(32'd2, 32'd2, 32'd0, 0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      int mdel, mode;
      mdel = ($urandom_range(0, 9) == 0) ? MT - 1 : int'($urandom_range(0, 5));
      mode = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
      do_mac(pick(), pick(), pick(), mdel, int'($urandom_range(0, 4)), mode);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
